// File: rtl/mac_sched_pkg.sv
// Shared op codes, operand widths and tag/result layouts for the MAC op scheduler.
package mac_sched_pkg;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_MUL6  = 2'b01;
    localparam logic [1:0] OP_MUL12 = 2'b10;
    localparam logic [1:0] OP_ADD3  = 2'b11;

    localparam int AB_W  = 6;
    localparam int C_W   = 12;
    localparam int RES_W = 24;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    typedef struct packed {
        logic             id;
        logic [RES_W-1:0] data;
    } result_t;
endpackage

// File: rtl/result_fifo.sv
// Show-ahead result FIFO with occupancy count; head reads zero while empty.
// Push/pop in the same cycle keep count unchanged; upstream credit keeps it from overflowing.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_en;
    logic             pop_en;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_check: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));
endmodule

// File: rtl/mac_op_scheduler.sv
// Round-robin scheduler sharing one mul/add datapath between two requesters; result 3 cycles after fire.
// Grants only while fifo entries plus in-flight ops stay below FIFO_DEPTH; res_ready stalls the FIFO head.
module mac_op_scheduler
    import mac_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DP_LAT     = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [AB_W-1:0]  req0_a,
    input  logic [AB_W-1:0]  req0_b,
    input  logic [C_W-1:0]   req0_c,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [AB_W-1:0]  req1_a,
    input  logic [AB_W-1:0]  req1_b,
    input  logic [C_W-1:0]   req1_c,
    output logic [AB_W-1:0]  dp_a,
    output logic [AB_W-1:0]  dp_b,
    output logic [C_W-1:0]   dp_c,
    output logic [1:0]       dp_control,
    input  logic [RES_W-1:0] dp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [RES_W-1:0] res_data
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + DP_LAT + 2);

    tag_t            tags [DP_LAT+1];
    logic            last_id;
    logic            credit;
    logic            gnt0;
    logic            gnt1;
    logic            fire;
    logic            gnt_id;
    logic [1:0]      sel_op;
    logic [AB_W-1:0] sel_a;
    logic [AB_W-1:0] sel_b;
    logic [C_W-1:0]  sel_c;
    logic [1:0]      op_q;
    logic [OW-1:0]   inflight;
    logic [OW-1:0]   occ;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    result_t         fifo_head;
    result_t         push_data;

    // Both terms are registered, so a pop only returns its credit on the following cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= DP_LAT; i++) begin
            inflight = inflight + OW'(tags[i].valid);
        end
    end

    assign occ    = OW'(fifo_count) + inflight;
    assign credit = (occ < OW'(FIFO_DEPTH));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && credit) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_id;
                gnt1 = !last_id;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign fire       = gnt0 || gnt1;
    assign gnt_id     = gnt1;

    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_c  = req0_c;
        if (gnt1) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_c  = req1_c;
        end
    end

    // Operands lead the op code by one cycle to line up with the datapath's operand register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_id    <= 1'b1;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_c       <= '0;
            op_q       <= OP_NONE;
            dp_control <= OP_NONE;
            for (int i = 0; i <= DP_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (fire) begin
                last_id <= gnt_id;
            end
            dp_a       <= fire ? sel_a : '0;
            dp_b       <= fire ? sel_b : '0;
            dp_c       <= fire ? sel_c : '0;
            op_q       <= fire ? sel_op : OP_NONE;
            dp_control <= op_q;
            tags[0]    <= tag_t'{valid: fire, id: gnt_id};
            for (int i = 1; i <= DP_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign push_data = result_t'{id: tags[DP_LAT].id, data: dp_out};

    result_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(result_t))
    ) u_result_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tags[DP_LAT].valid),
        .push_data (push_data),
        .pop       (res_valid && res_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_valid = !fifo_empty;
    assign res_id    = fifo_head.id;
    assign res_data  = fifo_head.data;
endmodule

// File: tb/tb_mac_op_scheduler.sv
// Random and directed traffic against a datapath model; scoreboard checks results, grants and credit.
module tb_mac_op_scheduler;
    import mac_sched_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [5:0]  req0_a, req0_b, req1_a, req1_b;
    logic [11:0] req0_c, req1_c;
    logic [5:0]  dp_a, dp_b;
    logic [11:0] dp_c;
    logic [1:0]  dp_control;
    logic [23:0] dp_out;
    logic        res_valid, res_ready, res_id;
    logic [23:0] res_data;

    mac_op_scheduler dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_control(dp_control), .dp_out(dp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
    );

    typedef struct { logic [1:0] op; logic [5:0] a; logic [5:0] b; logic [11:0] c; } req_t;
    typedef struct { logic id; logic [23:0] data; int fire_cyc; bit exact; } exp_t;

    req_t pend0[$];
    req_t pend1[$];
    exp_t exp_q[$];
    int   gnt_log[$];
    int   errors = 0, checks = 0, cyc = 0;
    int   fire_count = 0, res_seen = 0, outstanding = 0;
    bit   m_last = 1'b1, fired0 = 1'b0, fired1 = 1'b0, exact_mode = 1'b0;
    bit   er0, er1;
    exp_t e_new, e_got;

    // Arithmetic straight from the op definitions on sign-extended operands.
    function automatic logic [23:0] ref_result(input logic [1:0] op, input logic [5:0] a,
                                               input logic [5:0] b, input logic [11:0] c);
        int sa, sb, sc, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sc = int'($signed(c));
        case (op)
            OP_MUL6:  r = sa * sb;
            OP_MUL12: r = sa * sc;
            OP_ADD3:  r = sa + sb + sc;
            default:  r = 0;
        endcase
        return r[23:0];
    endfunction

    function automatic req_t mk(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                                input logic [11:0] c);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.c = c;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk(2'($urandom_range(3, 0)), 6'($urandom), 6'($urandom), 12'($urandom));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Datapath stand-in: operand register, then output register driven by the op code.
    logic [5:0]  dpa_r, dpb_r;
    logic [11:0] dpc_r;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dpa_r <= '0; dpb_r <= '0; dpc_r <= '0; dp_out <= '0;
        end else begin
            dpa_r  <= dp_a;
            dpb_r  <= dp_b;
            dpc_r  <= dp_c;
            dp_out <= ref_result(dp_control, dpa_r, dpb_r, dpc_r);
        end
    end

    // Monitor: expected grants from outstanding-op count, fire capture, result scoreboard.
    always @(negedge clock) begin
        fired0 = 1'b0;
        fired1 = 1'b0;
        if (!reset_n) begin
            exp_q.delete();
            outstanding = 0;
            m_last = 1'b1;
            chk("reset_ready", {30'd0, req0_ready, req1_ready}, 0);
            chk("reset_res_valid", res_valid, 0);
        end else begin
            er0 = 1'b0;
            er1 = 1'b0;
            if (outstanding < FIFO_DEPTH) begin
                if (req0_valid && req1_valid) begin
                    if (m_last) er0 = 1'b1; else er1 = 1'b1;
                end else if (req0_valid) er0 = 1'b1;
                else if (req1_valid) er1 = 1'b1;
            end
            chk("ready0", req0_ready, er0);
            chk("ready1", req1_ready, er1);
            if (req0_valid && req0_ready) begin
                fired0 = 1'b1;
                e_new.id = 1'b0;
                e_new.data = ref_result(req0_op, req0_a, req0_b, req0_c);
            end else if (req1_valid && req1_ready) begin
                fired1 = 1'b1;
                e_new.id = 1'b1;
                e_new.data = ref_result(req1_op, req1_a, req1_b, req1_c);
            end
            if (fired0 || fired1) begin
                e_new.fire_cyc = cyc + 1;
                e_new.exact = exact_mode;
                exp_q.push_back(e_new);
                gnt_log.push_back(int'(e_new.id));
                m_last = e_new.id;
                fire_count++;
            end
            if (res_valid && res_ready) begin
                res_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d data=0x%06h, expected no result",
                             res_id, res_data);
                end else begin
                    e_got = exp_q.pop_front();
                    chk("res_id", res_id, e_got.id);
                    chk("res_data", res_data, e_got.data);
                    if (e_got.exact) chk("latency", cyc - e_got.fire_cyc, 3);
                    else chk("latency_min", (cyc - e_got.fire_cyc) >= 3, 1);
                end
                outstanding--;
            end
            if (fired0 || fired1) outstanding++;
        end
    end

    task automatic drive();
        if (fired0 && pend0.size() > 0) pend0.delete(0);
        if (fired1 && pend1.size() > 0) pend1.delete(0);
        req0_valid = (pend0.size() > 0);
        req1_valid = (pend1.size() > 0);
        if (req0_valid) begin
            req0_op = pend0[0].op; req0_a = pend0[0].a; req0_b = pend0[0].b; req0_c = pend0[0].c;
        end
        if (req1_valid) begin
            req1_op = pend1[0].op; req1_a = pend1[0].a; req1_b = pend1[0].b; req1_c = pend1[0].c;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk(name, (pend0.size() == 0 && pend1.size() == 0 && exp_q.size() == 0), 1);
    endtask

    initial begin
        int s, f0, seen0, n;
        reset_n = 1'b0;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD3; req0_a = 6'h11; req0_b = 6'h22; req0_c = 12'h333;
        req1_valid = 1'b1; req1_op = OP_MUL6; req1_a = 6'h05; req1_b = 6'h06; req1_c = 12'h007;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_dp_a", dp_a, 0);
        chk("reset_dp_b", dp_b, 0);
        chk("reset_dp_c", dp_c, 0);
        chk("reset_dp_control", dp_control, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_res_data", res_data, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Directed ops, isolated so the 3-cycle latency is exact.
        exact_mode = 1'b1;
        pend0.push_back(mk(OP_MUL6, 6'h3D, 6'd5, 12'd0));
        wait_drain("drain_dir_mul6", 20);
        pend1.push_back(mk(OP_MUL12, 6'd3, 6'd0, 12'd100));
        wait_drain("drain_dir_mul12", 20);
        pend0.push_back(mk(OP_ADD3, 6'd1, 6'd2, 12'hFFF));
        wait_drain("drain_dir_add3", 20);
        exact_mode = 1'b0;

        // Both requesters saturated: grants must alternate starting with req1.
        s = gnt_log.size();
        for (int i = 0; i < 8; i++) begin
            pend0.push_back(rnd_req());
            pend1.push_back(rnd_req());
        end
        wait_drain("drain_b2b", 200);
        chk("b2b_first_id", gnt_log[s], 1);
        for (int i = s + 1; i < gnt_log.size(); i++) chk("b2b_alternate", gnt_log[i], 1 - gnt_log[i-1]);

        // Consumer stalled with 8 pending: only FIFO_DEPTH ops may fire.
        res_ready = 1'b0;
        f0 = fire_count;
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(rnd_req());
            pend1.push_back(rnd_req());
        end
        repeat (12) step();
        chk("bp_fires", fire_count - f0, 4);
        @(negedge clock);
        chk("bp_stalled", {30'd0, req0_ready, req1_ready}, 0);
        step();
        res_ready = 1'b1;
        @(negedge clock);
        chk("bp_pop_same_cycle", req0_ready | req1_ready, 0);
        step();
        @(negedge clock);
        chk("bp_pop_next_cycle", req0_ready | req1_ready, 1);
        wait_drain("drain_bp", 200);

        // Reset one cycle after a fire discards that op and re-favours req0.
        f0 = fire_count;
        n = 0;
        pend0.push_back(mk(OP_MUL6, 6'($urandom), 6'($urandom), 12'd0));
        while (fire_count == f0 && n < 20) begin
            step();
            n++;
        end
        chk("rst_fire_seen", fire_count != f0, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        seen0 = res_seen;
        repeat (10) step();
        chk("rst_no_result", res_seen - seen0, 0);
        s = gnt_log.size();
        pend0.push_back(rnd_req());
        pend1.push_back(rnd_req());
        wait_drain("drain_rst_rr", 40);
        chk("rst_rr_req0_first", gnt_log[s], 0);

        // Valid withdrawn while not ready: no issue, pointer untouched; op=00 markers return 0.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) pend0.push_back(rnd_req());
        repeat (8) step();
        pend1.push_back(rnd_req());
        repeat (4) step();
        f0 = fire_count;
        pend1.delete();
        repeat (3) step();
        chk("drop_no_fire", fire_count - f0, 0);
        res_ready = 1'b1;
        wait_drain("drain_drop", 40);
        s = gnt_log.size();
        pend0.push_back(mk(OP_NONE, 6'($urandom), 6'($urandom), 12'($urandom)));
        pend1.push_back(mk(OP_NONE, 6'($urandom), 6'($urandom), 12'($urandom)));
        wait_drain("drain_marker", 40);
        chk("drop_rr_unchanged", gnt_log[s], 1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
